// File: rtl/ecc_rom_pkg.sv
// ecc_rom_pkg
// Shared definitions for the ECC constant-ROM fetch path:
//   - ROM geometry (64 words x 16 bits, 6-bit address)
//   - address region layout (four 16-word regions selected by addr[5:4])
//   - burst sequencer FSM state type
package ecc_rom_pkg;

    localparam int ROM_DEPTH   = 64;
    localparam int ROM_AW      = $clog2(ROM_DEPTH);
    localparam int ROM_DW      = 16;

    // Regions are the top two address bits: 0-15, 16-31, 32-47, 48-63.
    localparam int REGION_W    = 2;
    localparam int NUM_REGIONS = 1 << REGION_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [REGION_W-1:0] addr_region(input logic [ROM_AW-1:0] a);
        return a[ROM_AW-1 -: REGION_W];
    endfunction

endpackage

// File: rtl/rom_fetch_arb_rr_arbiter.sv
// rr_arbiter
// Round-robin pick over NREQ requesters. The search starts at the pointer;
// when advance is high the pointer moves to the requester after the one
// currently granted. Pointer resets to 0 (requester 0 has top priority).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   advance    : commit the current pick (move the pointer past it)
//   gnt        : one-hot pick, combinational from req and the pointer
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            ptr_int;
    logic          found;

    // Offset i from the pointer is checked in increasing order, so the first
    // hit is the requester nearest the pointer in rotating order.
    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        ptr_int = int'(ptr_q);
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (j == (ptr_int + i) % NREQ)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int j = 0; j < NREQ; j++) begin
                if (gnt[j]) begin
                    ptr_d = PW'((j + 1) % NREQ);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rom_fetch_arb.sv
// rom_fetch_arb
// Burst-read arbiter and sequencer for the 64x16 synchronous constant ROM.
// Grants one requester at a time (round robin), drives the ROM enable and
// address one word per cycle, and returns read data tagged with requester id
// and a last-word flag.
// Optional feature macro: ROM_ARB_PROT_EN adds per-requester region
// permissions (parameter REQ_REGION_MASK) and the rd_err reject pulse.
// Ports:
//   CLK, rst_n          : clock (rising edge), asynchronous active-low reset
//   req/req_base/req_len: per-requester request level, start address, length-1
//   gnt                 : one-hot, one-cycle grant pulse
//   busy                : FSM not in IDLE
//   rom_cen/rom_a/rom_q : ROM enable (active-low), address, read data
//   rd_valid/rd_data/rd_id/rd_last : returned word and its tags
//   rd_err              : burst rejected by region check (0 without the macro)
// Handshake: a requester holds req with stable base/len until it sees gnt,
// and drops req the cycle after gnt unless it wants another burst.
module rom_fetch_arb
    import ecc_rom_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = ROM_AW,
    parameter int DW   = ROM_DW
`ifdef ROM_ARB_PROT_EN
    ,
    parameter logic [NREQ*NUM_REGIONS-1:0] REQ_REGION_MASK = '1
`endif
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*AW-1:0]       req_base,
    input  logic [NREQ*4-1:0]        req_len,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     rom_cen,
    output logic [AW-1:0]            rom_a,
    input  logic [DW-1:0]            rom_q,
    output logic                     rd_valid,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(NREQ)-1:0]  rd_id,
    output logic                     rd_last,
    output logic                     rd_err
);

    localparam int IDW = $clog2(NREQ);

    fetch_state_e   state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic           rom_cen_q, rom_cen_d;
    logic           busy_q, busy_d;
    logic           rd_valid_q, rd_valid_d;
    logic [IDW-1:0] rd_id_q, rd_id_d;
    logic           rd_last_q, rd_last_d;

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] pick_oh;
    logic            arb_advance;
    logic [IDW-1:0]  pick_id;
    logic [AW-1:0]   sel_base;
    logic [3:0]      sel_len;

    // Requests are only considered in IDLE. The cycle right after a grant
    // pulse is also excluded: after a rejected burst the FSM is already back
    // in IDLE while the requester is still allowed to hold req for that cycle.
    assign arb_req     = (state_q == IDLE && gnt_q == '0) ? req : '0;
    assign arb_advance = (state_q == IDLE) && (pick_oh != '0);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk     (CLK),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (arb_advance),
        .gnt     (pick_oh)
    );

`ifdef ROM_ARB_PROT_EN
    logic [NUM_REGIONS-1:0] sel_mask;
    logic [AW-1:0]          end_addr;
    logic                   region_ok;
    logic                   rd_err_q, rd_err_d;
`endif

    // Steer the picked requester's id, base and length (and permissions).
    always_comb begin
        pick_id  = '0;
        sel_base = '0;
        sel_len  = '0;
`ifdef ROM_ARB_PROT_EN
        sel_mask = '0;
`endif
        for (int j = 0; j < NREQ; j++) begin
            if (pick_oh[j]) begin
                pick_id  = IDW'(j);
                sel_base = req_base[j*AW +: AW];
                sel_len  = req_len[j*4 +: 4];
`ifdef ROM_ARB_PROT_EN
                sel_mask = REQ_REGION_MASK[j*NUM_REGIONS +: NUM_REGIONS];
`endif
            end
        end
    end

`ifdef ROM_ARB_PROT_EN
    // Both end points are checked; a burst never spans more than two regions
    // (16 words max), so the ends cover every region touched, including wrap.
    always_comb begin
        end_addr  = sel_base + AW'(sel_len);
        region_ok = sel_mask[addr_region(sel_base)] & sel_mask[addr_region(end_addr)];
    end
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        gnt_d      = '0;
        rom_cen_d  = 1'b1;
        // Return pipeline: tags follow the enable by exactly one cycle.
        rd_valid_d = (state_q == ISSUE);
        rd_last_d  = (state_q == ISSUE) && (cnt_q == 4'd0);
        rd_id_d    = (state_q == ISSUE) ? id_q : rd_id_q;
`ifdef ROM_ARB_PROT_EN
        rd_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_oh != '0) begin
                    gnt_d = pick_oh;
`ifdef ROM_ARB_PROT_EN
                    if (!region_ok) begin
                        rd_err_d = 1'b1;
                        rd_id_d  = pick_id;
                    end else
`endif
                    begin
                        state_d   = ISSUE;
                        addr_d    = sel_base;
                        cnt_d     = sel_len;
                        id_d      = pick_id;
                        rom_cen_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                // cnt_q counts addresses still to issue after the current one.
                if (cnt_q == 4'd0) begin
                    state_d = DRAIN;
                end else begin
                    addr_d    = addr_q + AW'(1);
                    cnt_d     = cnt_q - 4'd1;
                    rom_cen_d = 1'b0;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            id_q       <= '0;
            gnt_q      <= '0;
            rom_cen_q  <= 1'b1;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            gnt_q      <= gnt_d;
            rom_cen_q  <= rom_cen_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_last_q  <= rd_last_d;
        end
    end

`ifdef ROM_ARB_PROT_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end
    assign rd_err = rd_err_q;
`else
    assign rd_err = 1'b0;
`endif

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign rom_cen  = rom_cen_q;
    assign rom_a    = addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rom_q;
    assign rd_id    = rd_id_q;
    assign rd_last  = rd_last_q;

endmodule

// File: doc/rom_fetch_arb.md
# rom_fetch_arb

Burst-read arbiter and sequencer for the 64×16 synchronous constant ROM of the ECC core. It accepts burst requests (base address, word count) from NREQ requesters, such as the point-arithmetic controller and the key loader. It grants one requester at a time in round-robin order and drives the ROM's active-low enable and address one word per cycle. It returns the ROM's one-cycle-latency read data to the requester, tagged with the requester ID and a last-word flag.

## Interface
- NREQ, 2: number of requesters (2..4)
- AW, 6: ROM address width
- DW, 16: ROM data width
- CLK  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester burst request level
- req_base  in  NREQ*AW  per-requester start address, slice i = [i*AW +: AW]
- req_len  in  NREQ*4  per-requester word count minus one (0 → 1 word, 15 → 16 words)
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- busy  out  1  burst in progress (state ≠ IDLE)
- rom_cen  out  1  ROM chip enable, active-low
- rom_a  out  AW  ROM address
- rom_q  in  DW  ROM read data
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  DW  read word; combinational pass-through of rom_q
- rd_id  out  $clog2(NREQ)  requester owning rd_data
- rd_last  out  1  final word of burst
- rd_err  out  1  burst rejected (see Configuration)

## Operation
- FSM states:
  - IDLE: if any req is high, run the round-robin pick, latch base, len and id, pulse gnt, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: rom_cen=0 and rom_a=current address for len+1 consecutive cycles. Address increments by 1 modulo 64, so 63 wraps to 0. After the last address, go to DRAIN.
  - DRAIN: rom_cen=1. The last word returns this cycle. Go to IDLE.
- Round-robin: the pointer moves to the requester after the one just granted. Search starts at the pointer. Pointer reset value is 0, so requester 0 has top priority after reset.
- req_base and req_len are sampled only at the grant edge. A requester holds req until it sees gnt and must drop it on the cycle after gnt unless it wants another burst. Dropping req before grant withdraws the request with no side effects.
- A requester that keeps req high is re-granted only after all other pending requesters have been served.
- rd_valid is rom_cen delayed one cycle. rd_id and rd_last are delayed with it.
- Reset mid-burst: the FSM returns to IDLE immediately, in-flight words are discarded, and no rd_valid is produced.
- Reset values: gnt=0, busy=0, rom_cen=1, rom_a=0, rd_valid=0, rd_id=0, rd_last=0, rd_err=0. rd_data follows rom_q, which the ROM resets to 0.
- All outputs except rd_data are registered.

## Timing
- Grant edge E0: after E0, gnt pulses, rom_cen=0 and rom_a=base.
- ROM captures at E1, so the first rd_valid/rd_data appear after E1. Request-to-first-data latency is 2 edges.
- A burst of L words occupies L+2 cycles, IDLE through DRAIN. Throughput within a burst is one word per cycle.
- The next grant can occur at the IDLE cycle after DRAIN, giving a 2-cycle gap between bursts.

## Configuration
- ROM_ARB_PROT_EN defined:
  - Adds parameter REQ_REGION_MASK, NREQ*4 bits, default all ones. Bit r of slice i permits requester i to access region r, where region = addr[5:4] (0–15, 16–31, 32–47, 48–63).
  - At the grant edge, the regions of base and of (base+len) mod 64 are checked. If either is disallowed, the request is rejected:
    - gnt pulses and rd_err pulses in the same cycle, with rd_id set to the requester.
    - No ROM access occurs and the FSM returns to IDLE.
    - The round-robin pointer advances as for a normal grant.
- ROM_ARB_PROT_EN undefined: no check is performed, rd_err is tied 0, and REQ_REGION_MASK is absent.

## Structure
- Package ecc_rom_pkg: ROM_AW, ROM_DW, ROM_DEPTH=64, region-index constants, FSM state typedef (IDLE, ISSUE, DRAIN).
- Sub-module rr_arbiter: parameterised round-robin pick over NREQ, with inputs req and advance, and a one-hot grant output. The FSM, address counter and return pipeline stay in rom_fetch_arb.

## Test plan
- Single burst: requester 0, base 0, len 2 → rd_data 0xdcdc, 0x34b2, 0x8faa on consecutive cycles, rd_id 0, rd_last on the third word, first word 2 edges after req.
- Wrap-around: base 63, len 1 → 0x0ca6 then 0xdcdc, with rom_a sequence 63, 0.
- Contention: req 0 and 1 both high; req0 is base 48 len 1, req1 is base 16 len 0:
  - req0 is granted first, returning 0x2b7e, 0x1516.
  - req1 is granted next, returning 0x78f6 with rd_id 1.
  - Re-asserting req0 with req1 still high then grants req1.
- Reset mid-burst: assert rst_n low during ISSUE of a 16-word burst → rom_cen=1 and rd_valid=0 immediately. After release, the FSM is in IDLE and the pointer is at 0.
- Full 16-word burst: base 48, len 15 → 0x2b7e … 0x0ca6 in order, with rom_cen low for exactly 16 cycles.
- With ROM_ARB_PROT_EN and requester 1 mask 4'b0001: base 12, len 7 spans into region 1 → gnt and rd_err pulse together, rom_cen stays 1, and no rd_valid occurs.
